// File: rtl/zz_scan_arb.sv
// Two-source block arbiter in front of a zigzag scan engine; each reordered
// output block is tagged with the ID of the source that supplied it.
module zz_scan_arb #(
   parameter int DW        = 10,
   parameter int BLK_LEN   = 64,
   parameter int GAP       = 1,
   parameter int TAG_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic [DW-1:0] din0,
   input  logic [DW-1:0] din1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          scan_vld,
   output logic [DW-1:0] scan_din,
   input  logic          scan_vld_out,
   input  logic [DW-1:0] scan_dout,
   output logic          vld_out,
   output logic [DW-1:0] dout,
   output logic          out_id,
   output logic          out_sob,
   output logic          out_eob,
   output logic          err_orphan,
   output logic          busy
);
   localparam int BW = $clog2(BLK_LEN);
   localparam int PW = $clog2(TAG_DEPTH);
   localparam int CW = PW + 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_GAP} state_t;

   state_t          state_q;
   logic [BW-1:0]   beat_cnt_q;
   logic [GW-1:0]   gap_cnt_q;
   logic            last_q;
   logic            gnt0_q, gnt1_q;
   logic            scan_vld_q;
   logic [DW-1:0]   scan_din_q;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   tag_cnt_q, tag_cnt_d;
   logic            tag_mem [TAG_DEPTH];
   logic [BW-1:0]   out_cnt_q;
   logic            vld_out_q, out_id_q, out_sob_q, out_eob_q, err_q, busy_q;
   logic [DW-1:0]   dout_q;

   logic tag_full, tag_empty, winner, push, pop, feed_last, gap_last, out_last, busy_d;

   assign tag_full  = (tag_cnt_q == CW'(TAG_DEPTH));
   assign tag_empty = (tag_cnt_q == '0);
   // Contention goes to whoever did not win last; a lone requester always wins.
   assign winner    = (req0 & req1) ? ~last_q : req1;
   assign push      = (state_q == S_IDLE) && (req0 | req1) && !tag_full;
   assign feed_last = (state_q == S_FEED) && (beat_cnt_q == BW'(BLK_LEN - 1));
   assign gap_last  = (gap_cnt_q == GW'(GAP - 1));
   assign out_last  = (out_cnt_q == BW'(BLK_LEN - 1));
   assign pop       = scan_vld_out && out_last && !tag_empty;
   assign tag_cnt_d = tag_cnt_q + CW'(push) - CW'(pop);
   assign busy_d    = push
                    || ((state_q == S_FEED) && !(feed_last && (GAP == 0)))
                    || ((state_q == S_GAP) && !gap_last)
                    || (tag_cnt_d != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         beat_cnt_q <= '0;
         gap_cnt_q  <= '0;
         last_q     <= 1'b1;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (push) begin
                  gnt0_q     <= ~winner;
                  gnt1_q     <= winner;
                  last_q     <= winner;
                  beat_cnt_q <= '0;
                  state_q    <= S_FEED;
               end
            end
            S_FEED: begin
               beat_cnt_q <= beat_cnt_q + 1'b1;
               if (feed_last) begin
                  gnt0_q    <= 1'b0;
                  gnt1_q    <= 1'b0;
                  gap_cnt_q <= '0;
                  state_q   <= (GAP == 0) ? S_IDLE : S_GAP;
               end
            end
            S_GAP: begin
               gap_cnt_q <= gap_cnt_q + 1'b1;
               if (gap_last) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr_q] <= winner;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_vld_q <= 1'b0;
         scan_din_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tag_cnt_q  <= '0;
         out_cnt_q  <= '0;
         vld_out_q  <= 1'b0;
         dout_q     <= '0;
         out_id_q   <= 1'b0;
         out_sob_q  <= 1'b0;
         out_eob_q  <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         scan_vld_q <= gnt0_q | gnt1_q;
         scan_din_q <= gnt1_q ? din1 : (gnt0_q ? din0 : '0);
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         tag_cnt_q  <= tag_cnt_d;
         // Beats with no outstanding tag are still forwarded, tagged as source 0.
         vld_out_q  <= scan_vld_out;
         dout_q     <= scan_vld_out ? scan_dout : '0;
         out_id_q   <= scan_vld_out && !tag_empty && tag_mem[rd_ptr_q];
         out_sob_q  <= scan_vld_out && (out_cnt_q == '0);
         out_eob_q  <= scan_vld_out && out_last;
         if (scan_vld_out) out_cnt_q <= out_cnt_q + 1'b1;
         if (scan_vld_out && tag_empty) err_q <= 1'b1;
         busy_q     <= busy_d;
      end
   end

   assign gnt0       = gnt0_q;
   assign gnt1       = gnt1_q;
   assign scan_vld   = scan_vld_q;
   assign scan_din   = scan_din_q;
   assign vld_out    = vld_out_q;
   assign dout       = dout_q;
   assign out_id     = out_id_q;
   assign out_sob    = out_sob_q;
   assign out_eob    = out_eob_q;
   assign err_orphan = err_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_zz_scan_arb.sv
// Bench for zz_scan_arb: random sources and a behavioural scan engine, with
// block-level records checked against round-robin and tag-order rules.
module tb_zz_scan_arb;
   localparam int DW = 10;
   localparam int BL = 64;
   localparam int GAP = 1;
   localparam int TD = 4;
   localparam int BIG = 32'h7fff_ffff;

   logic clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0;
   logic [DW-1:0] din0 = '0, din1 = '0, scan_dout = '0;
   logic scan_vld_out = 1'b0;
   logic gnt0, gnt1, scan_vld, vld_out, out_id, out_sob, out_eob, err_orphan, busy;
   logic [DW-1:0] scan_din, dout;

   zz_scan_arb #(.DW(DW), .BLK_LEN(BL), .GAP(GAP), .TAG_DEPTH(TD)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
      .gnt0(gnt0), .gnt1(gnt1), .scan_vld(scan_vld), .scan_din(scan_din),
      .scan_vld_out(scan_vld_out), .scan_dout(scan_dout), .vld_out(vld_out),
      .dout(dout), .out_id(out_id), .out_sob(out_sob), .out_eob(out_eob),
      .err_orphan(err_orphan), .busy(busy));

   always #5 clk = ~clk;

   typedef struct { int id; int start; int len; } blk_t;
   typedef struct { logic [DW-1:0] d; int cyc; } beat_t;
   typedef struct { logic [DW-1:0] d; int cyc; logic id; logic sob; logic eob; } obs_t;

   blk_t gblk_q[$];
   beat_t src_q[$], scan_q[$], emit_q[$];
   obs_t out_q[$];
   logic [DW-1:0] eng_q[$];
   bit [1:0] req_hist [int];
   int cyc = 0, cur_len = 0, cur_id = 0, cur_start = 0, both_cnt = 0;
   int emitted = 0, credit = BIG, orph_pend = 0;
   int n_chk = 0, n_pass = 0;

   // One clock: observe registered outputs, then drive sources and engine.
   task automatic tick();
      req_hist[cyc] = {req1, req0};
      @(negedge clk);
      cyc++;
      if (gnt0 && gnt1) both_cnt++;
      if (gnt0 || gnt1) begin
         if (cur_len == 0) begin cur_id = gnt1 ? 1 : 0; cur_start = cyc; end
         cur_len++;
      end else if (cur_len != 0) begin
         gblk_q.push_back('{id: cur_id, start: cur_start, len: cur_len});
         cur_len = 0;
      end
      if (scan_vld) scan_q.push_back('{d: scan_din, cyc: cyc});
      if (vld_out) out_q.push_back('{d: dout, cyc: cyc, id: out_id, sob: out_sob, eob: out_eob});
      din0 = DW'($urandom);
      din1 = DW'($urandom);
      if (gnt0) src_q.push_back('{d: din0, cyc: cyc});
      if (gnt1) src_q.push_back('{d: din1, cyc: cyc});
      scan_vld_out = 1'b0;
      scan_dout    = '0;
      if (!rst_n) eng_q.delete();
      else if (orph_pend > 0) begin
         scan_vld_out = 1'b1; scan_dout = DW'($urandom); orph_pend--;
         emit_q.push_back('{d: scan_dout, cyc: cyc});
      end else if (eng_q.size() > 0 && emitted < credit) begin
         scan_vld_out = 1'b1; scan_dout = eng_q.pop_front(); emitted++;
         emit_q.push_back('{d: scan_dout, cyc: cyc});
      end
      if (rst_n && scan_vld) eng_q.push_back(scan_din);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      gblk_q.delete(); src_q.delete(); scan_q.delete(); emit_q.delete(); out_q.delete();
      eng_q.delete(); req_hist.delete();
      cur_len = 0; both_cnt = 0; emitted = 0; credit = BIG; orph_pend = 0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (!busy && !gnt0 && !gnt1 && !scan_vld && !vld_out && !scan_vld_out &&
             eng_q.size() == 0 && orph_pend == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [DW-1:0] obs [11];
      string nm [11];
      obs = '{DW'(gnt0), DW'(gnt1), DW'(scan_vld), scan_din, DW'(vld_out), dout,
              DW'(out_id), DW'(out_sob), DW'(out_eob), DW'(err_orphan), DW'(busy)};
      nm  = '{"gnt0", "gnt1", "scan_vld", "scan_din", "vld_out", "dout",
              "out_id", "out_sob", "out_eob", "err_orphan", "busy"};
      for (int i = 0; i < 11; i++) begin
         n_chk++;
         if (obs[i] !== '0) $display("FAIL reset_%s: got %0h expected 0", nm[i], obs[i]);
         else n_pass++;
      end
   endtask

   // Scan stream equals granted samples one cycle later; output beats follow
   // engine beats one cycle later, tagged in grant order, framed per BL beats.
   task automatic test_datapath();
      bit bad;
      int exp_id;
      n_chk++;
      if (scan_q.size() !== src_q.size())
         $display("FAIL scan_count: got %0d expected %0d", scan_q.size(), src_q.size());
      else n_pass++;
      bad = 1'b0;
      for (int i = 0; i < scan_q.size() && i < src_q.size() && !bad; i++) begin
         n_chk++;
         if (scan_q[i].d !== src_q[i].d || scan_q[i].cyc !== src_q[i].cyc + 1) begin
            $display("FAIL scan_beat%0d: got %0h@%0d expected %0h@%0d", i,
                     scan_q[i].d, scan_q[i].cyc, src_q[i].d, src_q[i].cyc + 1);
            bad = 1'b1;
         end else n_pass++;
      end
      n_chk++;
      if (out_q.size() !== emit_q.size())
         $display("FAIL out_count: got %0d expected %0d", out_q.size(), emit_q.size());
      else n_pass++;
      bad = 1'b0;
      for (int i = 0; i < out_q.size() && i < emit_q.size() && !bad; i++) begin
         exp_id = (i / BL < gblk_q.size()) ? gblk_q[i / BL].id : 0;
         n_chk++;
         if ({out_q[i].d, out_q[i].id, out_q[i].sob, out_q[i].eob} !==
             {emit_q[i].d, 1'(exp_id), 1'(i % BL == 0), 1'(i % BL == BL - 1)} ||
             out_q[i].cyc !== emit_q[i].cyc + 1) begin
            $display("FAIL out_beat%0d: got d=%0h id=%0d sob=%0d eob=%0d @%0d expected d=%0h id=%0d sob=%0d eob=%0d @%0d",
                     i, out_q[i].d, out_q[i].id, out_q[i].sob, out_q[i].eob, out_q[i].cyc,
                     emit_q[i].d, exp_id, (i % BL == 0), (i % BL == BL - 1), emit_q[i].cyc + 1);
            bad = 1'b1;
         end else n_pass++;
      end
      src_q.delete(); scan_q.delete(); emit_q.delete(); out_q.delete(); gblk_q.delete();
   endtask

   task automatic test_single();
      bit ok;
      int t0;
      req0 = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 10 && cur_len == 0; i++) tick();
      req0 = 1'b0;
      wait_idle(ok);
      n_chk++;
      if (!ok) $display("FAIL single_drain: got busy expected idle"); else n_pass++;
      n_chk++;
      if (gblk_q.size() !== 1) $display("FAIL single_blocks: got %0d expected 1", gblk_q.size());
      else n_pass++;
      if (gblk_q.size() > 0) begin
         n_chk++;
         if (gblk_q[0].id !== 0 || gblk_q[0].len !== BL || gblk_q[0].start !== t0 + 1)
            $display("FAIL single_gnt: got id=%0d len=%0d start=%0d expected id=0 len=%0d start=%0d",
                     gblk_q[0].id, gblk_q[0].len, gblk_q[0].start, BL, t0 + 1);
         else n_pass++;
      end
   endtask

   task automatic test_contention();
      bit ok;
      int exp_ids [4] = '{0, 1, 0, 1};
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 1000 && !(gblk_q.size() == 3 && cur_len > 0); i++) tick();
      req0 = 1'b0; req1 = 1'b0;
      wait_idle(ok);
      n_chk++;
      if (!ok) $display("FAIL contention_drain: got busy expected idle"); else n_pass++;
      n_chk++;
      if (gblk_q.size() !== 4 || both_cnt !== 0)
         $display("FAIL contention_blocks: got %0d blocks (%0d overlap) expected 4 (0)", gblk_q.size(), both_cnt);
      else n_pass++;
      for (int k = 0; k < gblk_q.size() && k < 4; k++) begin
         n_chk++;
         if (gblk_q[k].id !== exp_ids[k] || gblk_q[k].len !== BL)
            $display("FAIL contention_blk%0d: got id=%0d len=%0d expected id=%0d len=%0d",
                     k, gblk_q[k].id, gblk_q[k].len, exp_ids[k], BL);
         else n_pass++;
         if (k > 0) begin
            n_chk++;
            if (gblk_q[k].start - gblk_q[k-1].start - BL !== GAP + 1)
               $display("FAIL contention_gap%0d: got %0d low cycles expected %0d",
                        k, gblk_q[k].start - gblk_q[k-1].start - BL, GAP + 1);
            else n_pass++;
         end
      end
   endtask

   task automatic test_tag_full();
      bit ok;
      int p;
      credit = 0;
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 400; i++) tick();
      n_chk++;
      if (gblk_q.size() !== TD || cur_len !== 0 || busy !== 1'b1)
         $display("FAIL tagfull_hold: got %0d blocks gnt_active=%0d busy=%0d expected %0d 0 1",
                  gblk_q.size(), cur_len != 0, busy, TD);
      else n_pass++;
      credit = emitted + BL;
      for (int i = 0; i < 300 && emitted < BL; i++) tick();
      n_chk++;
      if (emitted !== BL) $display("FAIL tagfull_release: got %0d beats expected %0d", emitted, BL);
      else n_pass++;
      p = (emit_q.size() >= BL) ? emit_q[BL-1].cyc : 0;
      for (int i = 0; i < 10 && cur_len == 0; i++) tick();
      n_chk++;
      if (cur_len == 0 || cur_start !== p + 2 || cur_id !== 0)
         $display("FAIL tagfull_fifth: got start=%0d id=%0d active=%0d expected start=%0d id=0 active=1",
                  cur_start, cur_id, cur_len != 0, p + 2);
      else n_pass++;
      req0 = 1'b0; req1 = 1'b0;
      credit = BIG;
      wait_idle(ok);
      n_chk++;
      if (!ok || gblk_q.size() !== TD + 1)
         $display("FAIL tagfull_drain: got idle=%0d blocks=%0d expected 1 %0d", ok, gblk_q.size(), TD + 1);
      else n_pass++;
   endtask

   task automatic test_orphan();
      orph_pend = 3;
      for (int i = 0; i < 10; i++) tick();
      n_chk++;
      if (out_q.size() !== 3) $display("FAIL orphan_beats: got %0d expected 3", out_q.size());
      else n_pass++;
      n_chk++;
      if (err_orphan !== 1'b1 || busy !== 1'b0)
         $display("FAIL orphan_flag: got err=%0d busy=%0d expected 1 0", err_orphan, busy);
      else n_pass++;
      for (int i = 0; i < 20; i++) tick();
      n_chk++;
      if (err_orphan !== 1'b1) $display("FAIL orphan_sticky: got %0d expected 1", err_orphan);
      else n_pass++;
   endtask

   task automatic test_reset_mid_feed();
      bit ok;
      do_reset();
      n_chk++;
      if (err_orphan !== 1'b0) $display("FAIL orphan_cleared: got %0d expected 0", err_orphan);
      else n_pass++;
      req0 = 1'b1;
      for (int i = 0; i < 100 && !(gnt0 && cur_len == 31); i++) tick();
      n_chk++;
      if (cur_len !== 31) $display("FAIL midfeed_reach: got %0d beats expected 31", cur_len);
      else n_pass++;
      rst_n = 1'b0; req0 = 1'b0;
      tick();
      n_chk++;
      if ({gnt0, gnt1, scan_vld, busy} !== 4'b0)
         $display("FAIL midfeed_reset: got gnt0=%0d gnt1=%0d scan_vld=%0d busy=%0d expected all 0",
                  gnt0, gnt1, scan_vld, busy);
      else n_pass++;
      do_reset();
      req1 = 1'b1;
      for (int i = 0; i < 10 && cur_len == 0; i++) tick();
      req1 = 1'b0;
      wait_idle(ok);
      n_chk++;
      if (!ok || gblk_q.size() !== 1 || (gblk_q.size() > 0 && (gblk_q[0].id !== 1 || gblk_q[0].len !== BL)))
         $display("FAIL midfeed_after: got idle=%0d blocks=%0d expected 1 1 clean gnt1 block", ok, gblk_q.size());
      else n_pass++;
   endtask

   task automatic test_random();
      bit ok;
      bit rr_last;
      bit [1:0] r;
      int exp_id;
      do_reset();
      rr_last = 1'b1;
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 7) == 0) req0 = ~req0;
         if ($urandom_range(0, 7) == 0) req1 = ~req1;
         tick();
      end
      req0 = 1'b0; req1 = 1'b0;
      wait_idle(ok);
      n_chk++;
      if (!ok || both_cnt !== 0 || gblk_q.size() < 3)
         $display("FAIL random_run: got idle=%0d overlap=%0d blocks=%0d expected 1 0 >=3", ok, both_cnt, gblk_q.size());
      else n_pass++;
      for (int k = 0; k < gblk_q.size(); k++) begin
         r = req_hist.exists(gblk_q[k].start - 1) ? req_hist[gblk_q[k].start - 1] : 2'b00;
         exp_id = (r == 2'b11) ? int'(!rr_last) : int'(r[1]);
         rr_last = exp_id[0];
         n_chk++;
         if (r == 2'b00 || gblk_q[k].id !== exp_id || gblk_q[k].len !== BL)
            $display("FAIL random_blk%0d: got id=%0d len=%0d req=%0b expected id=%0d len=%0d",
                     k, gblk_q[k].id, gblk_q[k].len, r, exp_id, BL);
         else n_pass++;
         if (k > 0) begin
            n_chk++;
            if (gblk_q[k].start - gblk_q[k-1].start - BL < GAP + 1)
               $display("FAIL random_gap%0d: got %0d low cycles expected >=%0d",
                        k, gblk_q[k].start - gblk_q[k-1].start - BL, GAP + 1);
            else n_pass++;
         end
      end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_single();
      test_datapath();
      do_reset();
      test_contention();
      test_datapath();
      do_reset();
      test_tag_full();
      test_datapath();
      do_reset();
      test_orphan();
      test_datapath();
      test_reset_mid_feed();
      test_datapath();
      test_random();
      test_datapath();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
